store_unit: RTL and testbench

STORE_UNIT -- requirements
Module: store_unit

---
 rtl/config_pkg.sv | 37 +++
 rtl/store_data_align.sv | 27 ++
 rtl/store_unit.sv | 148 ++++++++++++++
 tb/tb_store_unit.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/config_pkg.sv
// Shared configuration for the store unit: datapath widths, exception cause
// codes, the FSM state type, the latched store-request record and the
// alignment rule.
package config_pkg;

  localparam int unsigned XLEN = 64;
  localparam int unsigned PLEN = 56;

  localparam logic [XLEN-1:0] ST_ADDR_MISALIGNED = 64'd6;
  localparam logic [XLEN-1:0] STORE_PAGE_FAULT   = 64'd15;

  typedef enum logic [1:0] {
    StIdle,
    StTranslate,
    StStore,
    StResult
  } store_state_e;

  typedef struct packed {
    logic [XLEN-1:0] vaddr;
    logic [XLEN-1:0] data;
    logic [1:0]      size;
  } store_req_t;

  // Natural alignment: the access must not cross its own size boundary.
  function automatic logic is_misaligned(input logic [2:0] offset, input logic [1:0] size);
    logic mis;
    case (size)
      2'd0:    mis = 1'b0;
      2'd1:    mis = offset[0];
      2'd2:    mis = |offset[1:0];
      default: mis = |offset;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/store_data_align.sv
// Places store data and byte enables on the correct byte lanes of the
// 64-bit store-buffer word, from the access size and vaddr[2:0].
module store_data_align
  import config_pkg::*;
(
  input  logic [XLEN-1:0]   data_i,
  input  logic [1:0]        size_i,
  input  logic [2:0]        offset_i,
  output logic [XLEN-1:0]   data_o,
  output logic [XLEN/8-1:0] be_o
);

  logic [7:0] mask;

  // Size mask shifted to the byte offset; data shifted by the same lane count.
  always_comb begin
    case (size_i)
      2'd0:    mask = 8'h01;
      2'd1:    mask = 8'h03;
      2'd2:    mask = 8'h0F;
      default: mask = 8'hFF;
    endcase
    be_o   = mask << offset_i;
    data_o = data_i << {offset_i, 3'b000};
  end

endmodule

// File: rtl/store_unit.sv
// Store unit: computes the store address, checks alignment, requests
// translation, hands the aligned store to the store buffer and reports the
// result (with any exception) to the scoreboard.
// Optional feature: define STORE_UNIT_RVFI_EN to add rvfi_mem_paddr_o, the
// physical address of the most recent store-buffer transfer.
module store_unit
  import config_pkg::*;
#(
  parameter int unsigned TRANS_ID_BITS = 3
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     valid_i,
  output logic                     ready_o,
  input  logic [XLEN-1:0]          base_i,
  input  logic [XLEN-1:0]          imm_i,
  input  logic [XLEN-1:0]          store_data_i,
  input  logic [1:0]               size_i,
  input  logic [TRANS_ID_BITS-1:0] trans_id_i,
  output logic                     translation_req_o,
  output logic [XLEN-1:0]          vaddr_o,
  input  logic                     translation_valid_i,
  input  logic [PLEN-1:0]          paddr_i,
  input  logic                     page_fault_i,
  output logic                     st_valid_o,
  output logic                     st_valid_without_flush_o,
  input  logic                     st_ready_i,
  output logic [PLEN-1:0]          st_paddr_o,
  output logic [XLEN-1:0]          st_data_o,
  output logic [XLEN/8-1:0]        st_be_o,
  output logic [1:0]               st_data_size_o,
  output logic                     result_valid_o,
  output logic [TRANS_ID_BITS-1:0] result_trans_id_o,
  output logic                     ex_valid_o,
  output logic [XLEN-1:0]          ex_cause_o,
  output logic [XLEN-1:0]          ex_tval_o
`ifdef STORE_UNIT_RVFI_EN
  ,
  output logic [PLEN-1:0]          rvfi_mem_paddr_o
`endif
);

  store_state_e             state_q;
  store_req_t               req_q;
  logic [TRANS_ID_BITS-1:0] trans_id_q;
  logic [PLEN-1:0]          paddr_q;
  logic                     ex_valid_q;
  logic [XLEN-1:0]          ex_cause_q;

  logic [XLEN-1:0]   vaddr_new;
  logic [XLEN-1:0]   aligned_data;
  logic [XLEN/8-1:0] aligned_be;
  logic              in_store;

  assign vaddr_new = base_i + imm_i;
  assign in_store  = (state_q == StStore);

  store_data_align u_align (
    .data_i   (req_q.data),
    .size_i   (req_q.size),
    .offset_i (req_q.vaddr[2:0]),
    .data_o   (aligned_data),
    .be_o     (aligned_be)
  );

  // Control FSM and latched request fields; flush wins over every state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      req_q      <= '0;
      trans_id_q <= '0;
      paddr_q    <= '0;
      ex_valid_q <= 1'b0;
      ex_cause_q <= '0;
    end else if (flush_i) begin
      state_q <= StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          if (valid_i) begin
            req_q      <= '{vaddr: vaddr_new, data: store_data_i, size: size_i};
            trans_id_q <= trans_id_i;
            ex_valid_q <= 1'b0;
            ex_cause_q <= '0;
            if (is_misaligned(vaddr_new[2:0], size_i)) begin
              ex_valid_q <= 1'b1;
              ex_cause_q <= ST_ADDR_MISALIGNED;
              state_q    <= StResult;
            end else begin
              state_q <= StTranslate;
            end
          end
        end
        StTranslate: begin
          if (translation_valid_i) begin
            if (page_fault_i) begin
              ex_valid_q <= 1'b1;
              ex_cause_q <= STORE_PAGE_FAULT;
              state_q    <= StResult;
            end else begin
              paddr_q <= paddr_i;
              state_q <= StStore;
            end
          end
        end
        // No flush here, so st_valid_o is high and st_ready_i completes the transfer.
        StStore:  if (st_ready_i) state_q <= StResult;
        StResult: state_q <= StIdle;
        default:  state_q <= StIdle;
      endcase
    end
  end

`ifdef STORE_UNIT_RVFI_EN
  logic [PLEN-1:0] rvfi_paddr_q;

  // Records the physical address of each completed store-buffer transfer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvfi_paddr_q <= '0;
    end else if (st_valid_o && st_ready_i) begin
      rvfi_paddr_q <= paddr_q;
    end
  end

  assign rvfi_mem_paddr_o = rvfi_paddr_q;
`endif

  // Outputs decoded from the registered state; store and exception fields are zero when idle.
  always_comb begin
    ready_o                  = (state_q == StIdle);
    translation_req_o        = (state_q == StTranslate);
    vaddr_o                  = req_q.vaddr;
    st_valid_without_flush_o = in_store;
    st_valid_o               = in_store && !flush_i;
    st_paddr_o               = in_store ? paddr_q : '0;
    st_data_o                = in_store ? aligned_data : '0;
    st_be_o                  = in_store ? aligned_be : '0;
    st_data_size_o           = in_store ? req_q.size : 2'd0;
    result_valid_o           = (state_q == StResult) && !flush_i;
    result_trans_id_o        = trans_id_q;
    ex_valid_o               = result_valid_o && ex_valid_q;
    ex_cause_o               = ex_valid_o ? ex_cause_q : '0;
    ex_tval_o                = ex_valid_o ? req_q.vaddr : '0;
  end

endmodule

// File: tb/tb_store_unit.sv
// Self-checking bench for store_unit: directed scenarios plus randomized
// transactions checked against an arithmetic model of the store rules.
module tb_store_unit;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        flush_i = 1'b0;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [63:0] base_i = '0;
  logic [63:0] imm_i = '0;
  logic [63:0] store_data_i = '0;
  logic [1:0]  size_i = '0;
  logic [2:0]  trans_id_i = '0;
  logic        translation_req_o;
  logic [63:0] vaddr_o;
  logic        translation_valid_i = 1'b0;
  logic [55:0] paddr_i = '0;
  logic        page_fault_i = 1'b0;
  logic        st_valid_o;
  logic        st_valid_without_flush_o;
  logic        st_ready_i = 1'b0;
  logic [55:0] st_paddr_o;
  logic [63:0] st_data_o;
  logic [7:0]  st_be_o;
  logic [1:0]  st_data_size_o;
  logic        result_valid_o;
  logic [2:0]  result_trans_id_o;
  logic        ex_valid_o;
  logic [63:0] ex_cause_o;
  logic [63:0] ex_tval_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  store_unit #(.TRANS_ID_BITS(3)) dut (
    .clk_i                    (clk_i),
    .rst_ni                   (rst_ni),
    .flush_i                  (flush_i),
    .valid_i                  (valid_i),
    .ready_o                  (ready_o),
    .base_i                   (base_i),
    .imm_i                    (imm_i),
    .store_data_i             (store_data_i),
    .size_i                   (size_i),
    .trans_id_i               (trans_id_i),
    .translation_req_o        (translation_req_o),
    .vaddr_o                  (vaddr_o),
    .translation_valid_i      (translation_valid_i),
    .paddr_i                  (paddr_i),
    .page_fault_i             (page_fault_i),
    .st_valid_o               (st_valid_o),
    .st_valid_without_flush_o (st_valid_without_flush_o),
    .st_ready_i               (st_ready_i),
    .st_paddr_o               (st_paddr_o),
    .st_data_o                (st_data_o),
    .st_be_o                  (st_be_o),
    .st_data_size_o           (st_data_size_o),
    .result_valid_o           (result_valid_o),
    .result_trans_id_o        (result_trans_id_o),
    .ex_valid_o               (ex_valid_o),
    .ex_cause_o               (ex_cause_o),
    .ex_tval_o                (ex_tval_o)
  );

  // Reference model: byte count, alignment, lane placement by arithmetic.
  function automatic int unsigned m_bytes(input logic [1:0] size);
    return 1 << size;
  endfunction

  function automatic bit m_misaligned(input logic [63:0] va, input logic [1:0] size);
    return (va % m_bytes(size)) != 0;
  endfunction

  function automatic logic [63:0] m_data(input logic [63:0] d, input logic [63:0] va);
    logic [63:0] scale;
    scale = 64'd1 << (8 * (va % 8));
    return d * scale;
  endfunction

  function automatic logic [7:0] m_be(input logic [1:0] size, input logic [63:0] va);
    logic [15:0] m;
    m = (16'd1 << m_bytes(size)) - 16'd1;
    m = m << (va % 8);
    return m[7:0];
  endfunction

  task automatic step();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  // One full transaction: tlat idle translate cycles, rdly stalled store cycles.
  task automatic run_txn(input string name, input logic [63:0] base, input logic [63:0] imm,
                         input logic [63:0] data, input logic [1:0] size, input logic [2:0] id,
                         input int tlat, input bit pf, input logic [55:0] paddr, input int rdly);
    logic [63:0] va;
    bit          mis;
    bit          exp_ex;
    logic [63:0] exp_cause;
    va  = base + imm;
    mis = m_misaligned(va, size);
    checks++;
    if (ready_o !== 1'b1) begin
      errors++;
      $display("FAIL %s idle_ready got %b want 1", name, ready_o);
    end
    valid_i = 1'b1; base_i = base; imm_i = imm; store_data_i = data;
    size_i = size; trans_id_i = id;
    step();
    valid_i = 1'b0; base_i = {$urandom, $urandom}; imm_i = {$urandom, $urandom};
    store_data_i = {$urandom, $urandom}; size_i = 2'($urandom); trans_id_i = 3'($urandom);
    if (!mis) begin
      for (int k = 0; k <= tlat; k++) begin
        checks++;
        if ({translation_req_o, vaddr_o, st_valid_o, ready_o, result_valid_o}
            !== {1'b1, va, 1'b0, 1'b0, 1'b0}) begin
          errors++;
          $display("FAIL %s translate req=%b vaddr=%h st_valid=%b ready=%b res=%b want req=1 vaddr=%h",
                   name, translation_req_o, vaddr_o, st_valid_o, ready_o, result_valid_o, va);
        end
        if (k == tlat) begin
          translation_valid_i = 1'b1; paddr_i = paddr; page_fault_i = pf;
        end
        step();
      end
      translation_valid_i = 1'b0; page_fault_i = 1'b0; paddr_i = 56'($urandom);
      if (!pf) begin
        for (int k = 0; k <= rdly; k++) begin
          checks++;
          if ({st_valid_o, st_valid_without_flush_o, st_paddr_o, st_data_o, st_be_o,
               st_data_size_o, translation_req_o, ready_o, result_valid_o}
              !== {1'b1, 1'b1, paddr, m_data(data, va), m_be(size, va), size, 3'b000}) begin
            errors++;
            $display("FAIL %s store v=%b vwf=%b pa=%h d=%h be=%h sz=%0d want pa=%h d=%h be=%h sz=%0d",
                     name, st_valid_o, st_valid_without_flush_o, st_paddr_o, st_data_o, st_be_o,
                     st_data_size_o, paddr, m_data(data, va), m_be(size, va), size);
          end
          st_ready_i = (k == rdly);
          step();
        end
        st_ready_i = 1'b0;
      end
    end
    exp_ex    = mis || pf;
    exp_cause = mis ? 64'd6 : 64'd15;
    checks++;
    if ({result_valid_o, result_trans_id_o, ex_valid_o, ex_cause_o, ex_tval_o, st_valid_o,
         translation_req_o}
        !== {1'b1, id, exp_ex, exp_ex ? exp_cause : 64'd0, exp_ex ? va : 64'd0, 2'b00}) begin
      errors++;
      $display("FAIL %s result rv=%b id=%0d ex=%b cause=%0d tval=%h stv=%b treq=%b want id=%0d ex=%b cause=%0d tval=%h",
               name, result_valid_o, result_trans_id_o, ex_valid_o, ex_cause_o, ex_tval_o,
               st_valid_o, translation_req_o, id, exp_ex, exp_ex ? exp_cause : 64'd0,
               exp_ex ? va : 64'd0);
    end
    step();
    checks++;
    if ({ready_o, result_valid_o} !== 2'b10) begin
      errors++;
      $display("FAIL %s back_to_idle ready=%b res=%b want ready=1 res=0", name, ready_o,
               result_valid_o);
    end
  endtask

  task automatic test_reset();
    @(negedge clk_i);
    checks++;
    if (ready_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got %b want 1", ready_o);
    end
    checks++;
    if ({translation_req_o, vaddr_o, st_valid_o, st_valid_without_flush_o, st_paddr_o, st_data_o,
         st_be_o, st_data_size_o, result_valid_o, result_trans_id_o, ex_valid_o, ex_cause_o,
         ex_tval_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs treq=%b vaddr=%h stv=%b be=%h res=%b id=%0d ex=%b want all 0",
               translation_req_o, vaddr_o, st_valid_o, st_be_o, result_valid_o,
               result_trans_id_o, ex_valid_o);
    end
    rst_ni = 1'b1;
    step();
  endtask

  task automatic test_directed();
    run_txn("sd_aligned", 64'h1000, 64'h8, 64'h1122334455667788, 2'd3, 3'd5, 0, 1'b0,
            56'h1008, 0);
    run_txn("sb_lane3", 64'h1000, 64'h3, 64'hAB, 2'd0, 3'd2, 0, 1'b0, 56'h1003, 0);
    run_txn("sw_misaligned", 64'h1000, 64'h2, 64'hDEADBEEF, 2'd2, 3'd7, 0, 1'b0, 56'h0, 0);
    run_txn("sh_page_fault", 64'h2000, 64'h0, 64'h1234, 2'd1, 3'd1, 1, 1'b1, 56'h0, 0);
    run_txn("sd_wrap", 64'hFFFFFFFFFFFFFFF8, 64'h10, 64'hCAFEF00D, 2'd3, 3'd3, 0, 1'b0,
            56'h8, 0);
  endtask

  task automatic test_flush_idle();
    valid_i = 1'b1; flush_i = 1'b1; base_i = 64'h3000; imm_i = '0; size_i = 2'd3;
    step();
    valid_i = 1'b0; flush_i = 1'b0;
    checks++;
    if ({ready_o, translation_req_o, result_valid_o} !== 3'b100) begin
      errors++;
      $display("FAIL flush_idle ready=%b treq=%b res=%b want 1,0,0", ready_o, translation_req_o,
               result_valid_o);
    end
  endtask

  task automatic test_flush_stall();
    valid_i = 1'b1; base_i = 64'h4000; imm_i = 64'h10; store_data_i = 64'h55; size_i = 2'd3;
    trans_id_i = 3'd4;
    step();
    valid_i = 1'b0;
    translation_valid_i = 1'b1; paddr_i = 56'h4010;
    step();
    translation_valid_i = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      if (c == 3) begin
        flush_i = 1'b1;
        #1;
        checks++;
        if ({st_valid_o, st_valid_without_flush_o} !== 2'b01) begin
          errors++;
          $display("FAIL flush_store stv=%b vwf=%b want 0,1", st_valid_o,
                   st_valid_without_flush_o);
        end
        step();
        flush_i = 1'b0;
        break;
      end
      checks++;
      if ({st_valid_o, ready_o} !== 2'b10) begin
        errors++;
        $display("FAIL stall_c%0d stv=%b ready=%b want 1,0", c, st_valid_o, ready_o);
      end
      step();
    end
    for (int c = 0; c < 3; c++) begin
      checks++;
      if ({ready_o, result_valid_o, st_valid_without_flush_o} !== 3'b100) begin
        errors++;
        $display("FAIL after_flush_c%0d ready=%b res=%b vwf=%b want 1,0,0", c, ready_o,
                 result_valid_o, st_valid_without_flush_o);
      end
      step();
    end
  endtask

  task automatic test_reset_midop();
    valid_i = 1'b1; base_i = 64'h5000; imm_i = '0; size_i = 2'd2; trans_id_i = 3'd6;
    step();
    valid_i = 1'b0;
    rst_ni = 1'b0;
    #1;
    checks++;
    if ({ready_o, translation_req_o, vaddr_o} !== {2'b10, 64'd0}) begin
      errors++;
      $display("FAIL async_reset ready=%b treq=%b vaddr=%h want 1,0,0", ready_o,
               translation_req_o, vaddr_o);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    translation_valid_i = 1'b1; paddr_i = 56'h5000;
    step();
    translation_valid_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if ({ready_o, result_valid_o, st_valid_without_flush_o} !== 3'b100) begin
        errors++;
        $display("FAIL reset_discard_c%0d ready=%b res=%b vwf=%b want 1,0,0", c, ready_o,
                 result_valid_o, st_valid_without_flush_o);
      end
      step();
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      run_txn("random", {$urandom, $urandom}, 64'($urandom_range(0, 255)), {$urandom, $urandom},
              2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), int'($urandom_range(0, 2)),
              ($urandom_range(0, 9) == 0), 56'({$urandom, $urandom}),
              int'($urandom_range(0, 2)));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_flush_idle();
    test_flush_stall();
    test_reset_midop();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
